// File: rtl/bpu_btb.sv
// bpu_btb -- fully associative branch target buffer for the fetch front end.
//
// Holds ENTRIES entries {valid, tag, target, 2-bit saturating counter} with
// round-robin allocation. The IT-stage PC is looked up combinationally, and
// the prediction is carried with the PC through the IC, ID and EX stages so
// that EX can compare it against the resolved branch. Branch resolution in
// EX updates a hit entry or allocates a new entry on a taken miss.
//
// Ports:
//   clk           single clock
//   resetn        asynchronous active-low reset
//   stall[5:0]    stall vector, 1 = Stop: bit1 IF/IT, bit2 IC/ID, bit3 EX, bit4 MEM
//   flush         exception flush: clears every tracked stage and masks bp_e
//   if_pc         PC entering IT
//   ex_br_valid   a branch/jump resolved in EX this cycle
//   ex_br_taken   resolved direction
//   ex_br_target  resolved target
//   ex_redirect   EX redirects fetch: clears IT/IC/ID, keeps EX
//   bp_bus        {bp_e, bp_target}: prediction for the IT-stage PC (combinational)
//   bp_to_ex_bus  {ex_bp_e, ex_bp_target}: prediction that travelled with the EX instruction
module bpu_btb #(
    parameter int ENTRIES = 8,
    parameter int PTR_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic        ex_br_valid,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        ex_redirect,
    output logic [32:0] bp_bus,
    output logic [32:0] bp_to_ex_bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic        bp_e;
        logic [31:0] target;
    } stage_t;

    localparam stage_t STAGE_CLR = '{pc: 32'h0, bp_e: 1'b0, target: 32'h0};

    // Entry storage
    logic [ENTRIES-1:0] valid_r;
    logic [31:0]        tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];
    logic [1:0]         cnt_r    [ENTRIES];
    logic [PTR_W-1:0]   rr_r;

    // Pipeline tracking
    logic [31:0] it_pc_r;
    stage_t      ic_r;
    stage_t      id_r;
    stage_t      ex_r;

    // Lookup results
    logic [ENTRIES-1:0] it_hits_s;
    logic [ENTRIES-1:0] ex_hits_s;
    logic               it_hit_s;
    logic [PTR_W-1:0]   it_idx_s;
    logic               ex_hit_s;
    logic [PTR_W-1:0]   ex_idx_s;
    logic               bp_e_s;
    logic [31:0]        bp_target_s;

    // Stage control
    logic front_clr_s;
    logic bub1_s;
    logic bub2_s;
    logic bub3_s;
    logic unused_s;

    // Lowest-index hit wins; returns {found, index}. Scanning downwards lets
    // the lowest hit overwrite any higher one.
    function automatic logic [PTR_W:0] first_hit(input logic [ENTRIES-1:0] hits);
        logic [PTR_W:0] res;
        res = {(PTR_W+1){1'b0}};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                res = {1'b1, PTR_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Tag compare of every entry against the IT-stage PC and the EX-stage PC
    always_comb begin
        it_hits_s = {ENTRIES{1'b0}};
        ex_hits_s = {ENTRIES{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            it_hits_s[i] = valid_r[i] && (tag_r[i] == it_pc_r);
            ex_hits_s[i] = valid_r[i] && (tag_r[i] == ex_r.pc);
        end
    end

    assign {it_hit_s, it_idx_s} = first_hit(it_hits_s);
    assign {ex_hit_s, ex_idx_s} = first_hit(ex_hits_s);

    // Prediction: taken only when the hit entry's counter is in a taken state
    always_comb begin
        bp_e_s      = ~flush & it_hit_s & cnt_r[it_idx_s][1];
        bp_target_s = 32'h0;
        if (bp_e_s) begin
            bp_target_s = target_r[it_idx_s];
        end else begin
            bp_target_s = 32'h0;
        end
    end

    assign bp_bus       = {bp_e_s, bp_target_s};
    assign bp_to_ex_bus = {ex_r.bp_e, ex_r.target};

    assign front_clr_s = flush | ex_redirect;
    assign bub1_s      = stall[1] & ~stall[2];
    assign bub2_s      = stall[2] & ~stall[3];
    assign bub3_s      = stall[3] & ~stall[4];
    // Stall bits 0 and 5 do not gate any stage tracked here.
    assign unused_s    = stall[0] ^ stall[5];

    // Entry update and round-robin allocation from EX branch resolution
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= {ENTRIES{1'b0}};
            rr_r    <= {PTR_W{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= 32'h0;
                target_r[i] <= 32'h0;
                cnt_r[i]    <= 2'b00;
            end
        end else if (ex_br_valid) begin
            if (ex_hit_s) begin
                if (ex_br_taken) begin
                    cnt_r[ex_idx_s]    <= (cnt_r[ex_idx_s] == 2'b11) ? 2'b11 : cnt_r[ex_idx_s] + 2'b01;
                    target_r[ex_idx_s] <= ex_br_target;
                end else begin
                    cnt_r[ex_idx_s] <= (cnt_r[ex_idx_s] == 2'b00) ? 2'b00 : cnt_r[ex_idx_s] - 2'b01;
                end
            end else if (ex_br_taken) begin
                // The victim is replaced regardless of its counter state.
                valid_r[rr_r]  <= 1'b1;
                tag_r[rr_r]    <= ex_r.pc;
                target_r[rr_r] <= ex_br_target;
                cnt_r[rr_r]    <= 2'b10;
                rr_r           <= rr_r + PTR_W'(1);
            end else begin
                rr_r <= rr_r;
            end
        end else begin
            rr_r <= rr_r;
        end
    end

    // IT stage: PC being looked up
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            it_pc_r <= 32'h0;
        end else if (front_clr_s) begin
            it_pc_r <= 32'h0;
        end else if (bub1_s) begin
            it_pc_r <= 32'h0;
        end else if (!stall[1]) begin
            it_pc_r <= if_pc;
        end else begin
            it_pc_r <= it_pc_r;
        end
    end

    // IC stage: captures the IT PC with the prediction made for it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ic_r <= STAGE_CLR;
        end else if (front_clr_s) begin
            ic_r <= STAGE_CLR;
        end else if (bub1_s) begin
            ic_r <= STAGE_CLR;
        end else if (!stall[1]) begin
            ic_r <= '{pc: it_pc_r, bp_e: bp_e_s, target: bp_target_s};
        end else begin
            ic_r <= ic_r;
        end
    end

    // ID stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_r <= STAGE_CLR;
        end else if (front_clr_s) begin
            id_r <= STAGE_CLR;
        end else if (bub2_s) begin
            id_r <= STAGE_CLR;
        end else if (!stall[2]) begin
            id_r <= ic_r;
        end else begin
            id_r <= id_r;
        end
    end

    // EX stage: survives a redirect (EX is the one issuing it), not a flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_r <= STAGE_CLR;
        end else if (flush) begin
            ex_r <= STAGE_CLR;
        end else if (bub3_s) begin
            ex_r <= STAGE_CLR;
        end else if (!stall[3]) begin
            ex_r <= id_r;
        end else begin
            ex_r <= ex_r;
        end
    end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb. Stimulus pushes expected bus values into a
// scoreboard tagged with the cycle they must appear in; a monitor on the
// falling edge pops and compares them.
module tb_bpu_btb;

    localparam int ENTRIES = 8;

    localparam logic [31:0] A  = 32'hBFC0_0010;
    localparam logic [31:0] TA = 32'hBFC0_0100;
    localparam logic [31:0] TB = 32'hBFC0_0200;
    localparam logic [31:0] Q  = 32'h0000_3000;
    localparam logic [31:0] TQ = 32'h0000_3300;
    localparam logic [31:0] R  = 32'h0000_4000;
    localparam logic [31:0] TR = 32'h0000_4400;
    localparam logic [32:0] NONE = 33'h0;

    logic        clk;
    logic        resetn;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] if_pc;
    logic        ex_br_valid;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_redirect;
    logic [32:0] bp_bus;
    logic [32:0] bp_to_ex_bus;

    bpu_btb #(.ENTRIES(ENTRIES)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .flush        (flush),
        .if_pc        (if_pc),
        .ex_br_valid  (ex_br_valid),
        .ex_br_taken  (ex_br_taken),
        .ex_br_target (ex_br_target),
        .ex_redirect  (ex_redirect),
        .bp_bus       (bp_bus),
        .bp_to_ex_bus (bp_to_ex_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          when;
        logic        ex_side;
        logic [32:0] val;
        int          scen;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc_n    = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          scen     = 0;
    int          mon_i;
    logic [32:0] mon_act;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < sb_q.size()) begin
            if (sb_q[mon_i].when <= cyc_n) begin
                mon_act = sb_q[mon_i].ex_side ? bp_to_ex_bus : bp_bus;
                n_checks++;
                if (mon_act === sb_q[mon_i].val && sb_q[mon_i].when == cyc_n) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s scen %0d cycle %0d: got %h required %h",
                             sb_q[mon_i].ex_side ? "bp_to_ex_bus" : "bp_bus",
                             sb_q[mon_i].scen, sb_q[mon_i].when, mon_act, sb_q[mon_i].val);
                end
                sb_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    function automatic logic [31:0] p_of(input int i);
        return 32'h0000_1000 + 32'(i) * 32'h0000_0010;
    endfunction

    function automatic logic [31:0] t_of(input int i);
        return 32'h0000_2000 + 32'(i) * 32'h0000_0004;
    endfunction

    function automatic logic [32:0] hit(input logic [31:0] tgt);
        return {1'b1, tgt};
    endfunction

    task automatic exp_bus(input logic ex_side, input logic [32:0] val);
        exp_t e;
        e.when    = cyc_n;
        e.ex_side = ex_side;
        e.val     = val;
        e.scen    = scen;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic [31:0] pc, input logic v, input logic t, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        if_pc        = pc;
        ex_br_valid  = v;
        ex_br_taken  = t;
        ex_br_target = tgt;
    endtask

    // Send one PC down an otherwise empty pipe: check its lookup in IT, the
    // carried prediction in EX, and apply a resolution in EX.
    task automatic send(input logic [31:0] pc, input logic v, input logic t, input logic [31:0] tgt,
                        input logic [32:0] eb, input logic [32:0] ee);
        cyc(pc, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0); exp_bus(1'b0, eb);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, v, t, tgt);         exp_bus(1'b1, ee);
    endtask

    initial begin
        resetn = 1'b0; stall = 6'b000000; flush = 1'b0; ex_redirect = 1'b0;
        if_pc = A; ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = TA;

        // Reset state with active inputs
        scen = 1;
        cyc(A, 1'b1, 1'b1, TA); exp_bus(1'b0, NONE); exp_bus(1'b1, NONE);
        cyc(A, 1'b1, 1'b1, TA); exp_bus(1'b0, NONE); exp_bus(1'b1, NONE);
        resetn = 1'b1; if_pc = 32'h0; ex_br_valid = 1'b0; ex_br_taken = 1'b0; ex_br_target = 32'h0;

        // Allocate A; same-cycle lookup sees old contents, next lookup hits
        scen = 2;
        cyc(A, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0); exp_bus(1'b0, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);
        cyc(A, 1'b0, 1'b0, 32'h0);
        cyc(A, 1'b1, 1'b1, TA);        exp_bus(1'b0, NONE); exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0); exp_bus(1'b0, hit(TA));
        cyc(32'h0, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0); exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b1, 1'b0, 32'h0); exp_bus(1'b1, hit(TA));

        // Counter hysteresis: cnt 1 -> 2 -> 3 (new target) -> 2
        scen = 3;
        send(A, 1'b1, 1'b1, TA, NONE, NONE);
        send(A, 1'b1, 1'b1, TB, hit(TA), hit(TA));
        send(A, 1'b1, 1'b0, 32'h0, hit(TB), hit(TB));
        send(A, 1'b0, 1'b0, 32'h0, hit(TB), hit(TB));

        // Wrap: P1..P7 fill entries 1..7, P8 evicts A from entry 0
        scen = 4;
        for (int i = 1; i <= 8; i++) begin
            send(p_of(i), 1'b1, 1'b1, t_of(i), NONE, NONE);
        end
        send(A, 1'b0, 1'b0, 32'h0, NONE, NONE);
        for (int i = 1; i <= 8; i++) begin
            send(p_of(i), 1'b0, 1'b0, 32'h0, hit(t_of(i)), hit(t_of(i)));
        end

        // Stalls: front stopped, EX free -> EX bubble while IT holds
        scen = 5;
        cyc(p_of(1), 1'b0, 1'b0, 32'h0);
        cyc(p_of(2), 1'b0, 1'b0, 32'h0); exp_bus(1'b0, hit(t_of(1)));
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   stall = 6'b000111; exp_bus(1'b0, hit(t_of(2)));
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   exp_bus(1'b0, hit(t_of(2))); exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   stall = 6'b000000; exp_bus(1'b0, hit(t_of(2))); exp_bus(1'b1, NONE);
        cyc(p_of(3), 1'b0, 1'b0, 32'h0); exp_bus(1'b1, NONE);
        cyc(p_of(4), 1'b0, 1'b0, 32'h0); exp_bus(1'b1, hit(t_of(1)));
        // Redirect during a stall: IT/IC/ID cleared, EX retained
        scen = 6;
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   stall = 6'b011111; ex_redirect = 1'b1;
        exp_bus(1'b1, hit(t_of(2))); exp_bus(1'b0, hit(t_of(4)));
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   stall = 6'b000000; ex_redirect = 1'b0;
        exp_bus(1'b0, NONE); exp_bus(1'b1, hit(t_of(2)));
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   exp_bus(1'b1, NONE);

        // Flush together with a taken miss in EX
        scen = 7;
        cyc(Q, 1'b0, 1'b0, 32'h0);
        cyc(p_of(6), 1'b0, 1'b0, 32'h0); exp_bus(1'b0, NONE);
        cyc(p_of(7), 1'b0, 1'b0, 32'h0);
        cyc(p_of(5), 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b1, 1'b1, TQ);      flush = 1'b1; exp_bus(1'b0, NONE); exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   flush = 1'b0; exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   exp_bus(1'b1, NONE);
        // Q went to entry 1 (rr was 1), evicting P1; rr is now 2
        send(Q, 1'b0, 1'b0, 32'h0, hit(TQ), hit(TQ));
        send(p_of(1), 1'b0, 1'b0, 32'h0, NONE, NONE);
        send(p_of(2), 1'b0, 1'b0, 32'h0, hit(t_of(2)), hit(t_of(2)));
        // Next taken miss lands in entry 2, evicting P2
        send(R, 1'b1, 1'b1, TR, NONE, NONE);
        send(p_of(2), 1'b0, 1'b0, 32'h0, NONE, NONE);
        send(p_of(3), 1'b0, 1'b0, 32'h0, hit(t_of(3)), hit(t_of(3)));

        // Asynchronous reset in the middle of a taken-miss update
        scen = 8;
        cyc(32'h0000_5000, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);
        cyc(p_of(3), 1'b0, 1'b0, 32'h0);
        cyc(32'h0, 1'b1, 1'b1, 32'h0000_5500);
        #2; resetn = 1'b0;
        #1;
        n_checks++;
        if (bp_bus === NONE) begin
            n_pass++;
        end else begin
            $display("FAIL bp_bus scen %0d immediate reset: got %h required %h", scen, bp_bus, NONE);
        end
        n_checks++;
        if (bp_to_ex_bus === NONE) begin
            n_pass++;
        end else begin
            $display("FAIL bp_to_ex_bus scen %0d immediate reset: got %h required %h", scen, bp_to_ex_bus, NONE);
        end
        exp_bus(1'b0, NONE); exp_bus(1'b1, NONE);
        cyc(32'h0, 1'b0, 1'b0, 32'h0);   exp_bus(1'b0, NONE); exp_bus(1'b1, NONE);
        resetn = 1'b1;
        send(32'h0000_5000, 1'b0, 1'b0, 32'h0, NONE, NONE);
        send(p_of(3), 1'b0, 1'b0, 32'h0, NONE, NONE);
        send(R, 1'b0, 1'b0, 32'h0, NONE, NONE);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        while (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain scen %0d cycle %0d: got no comparison required %h",
                     sb_q[0].scen, sb_q[0].when, sb_q[0].val);
            sb_q.delete(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
